// File: rtl/single_rx_uart.sv
// Single-channel UART receiver: 2-flop input synchroniser, mid-bit sampling,
// optional parity check, stop-bit check and a one-cycle strobe per frame.
module single_rx_uart #(
    parameter int    CLOCK     = 10_000_000,
    parameter int    BAUD      = 1_000_000,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int factor_int = (CLOCK + BAUD / 2) / BAUD;
    localparam int half_int   = factor_int / 2;
    localparam int cnt_w      = $clog2(factor_int);

    localparam logic [cnt_w-1:0] cnt_bit_end  = cnt_w'(factor_int - 1);
    localparam logic [cnt_w-1:0] cnt_half_end = cnt_w'(half_int - 1);

    localparam bit par_en    = (PARITY != "NO");
    localparam bit par_odd   = (PARITY == "ODD");
    localparam bit msb_first = (FIRST_BIT == "MSB");

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic [cnt_w-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_err_q;
    logic             rxd_m;
    logic             rxd_s;

    // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_err_q  <= 1'b0;
            rx_data    <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == cnt_half_end) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == cnt_bit_end) begin
                        cnt   <= '0;
                        shreg <= msb_first ? {shreg[6:0], rxd_s} : {rxd_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= par_en ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (cnt == cnt_bit_end) begin
                        cnt       <= '0;
                        par_err_q <= (^shreg) ^ rxd_s ^ par_odd;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                STOP: begin
                    if (cnt == cnt_bit_end) begin
                        cnt        <= '0;
                        rx_data    <= shreg;
                        parity_err <= par_en & par_err_q;
                        frame_err  <= ~rxd_s;
                        valid      <= 1'b1;
                        state      <= rxd_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_single_rx_uart.sv
// Directed bench for single_rx_uart: four receivers (NO/LSB, NO/MSB, EVEN, ODD),
// each fed by a bench-side frame generator at 10 clocks per bit.
module tb_single_rx_uart;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic line  = 1'b1;
    int   sel   = 0;
    int   cyc   = 0;
    int   e_cyc = 0;

    int vectors     = 0;
    int miscompares = 0;

    logic       rxd_lsb, rxd_msb, rxd_even, rxd_odd;
    logic [7:0] data_lsb, data_msb, data_even, data_odd;
    logic       valid_lsb, valid_msb, valid_even, valid_odd;
    logic       perr_lsb, perr_msb, perr_even, perr_odd;
    logic       ferr_lsb, ferr_msb, ferr_even, ferr_odd;
    logic       busy_lsb, busy_msb, busy_even, busy_odd;

    int n_lsb = 0, n_msb = 0, n_even = 0, n_odd = 0;
    int t_lsb = 0;
    int base, t1, t2;

    assign rxd_lsb  = (sel == 0) ? line : 1'b1;
    assign rxd_msb  = (sel == 1) ? line : 1'b1;
    assign rxd_even = (sel == 2) ? line : 1'b1;
    assign rxd_odd  = (sel == 3) ? line : 1'b1;

    single_rx_uart #(.PARITY("NO"), .FIRST_BIT("LSB")) u_lsb (
        .clk(clk), .reset(reset), .rxd(rxd_lsb), .rx_data(data_lsb), .valid(valid_lsb),
        .parity_err(perr_lsb), .frame_err(ferr_lsb), .busy(busy_lsb));
    single_rx_uart #(.PARITY("NO"), .FIRST_BIT("MSB")) u_msb (
        .clk(clk), .reset(reset), .rxd(rxd_msb), .rx_data(data_msb), .valid(valid_msb),
        .parity_err(perr_msb), .frame_err(ferr_msb), .busy(busy_msb));
    single_rx_uart #(.PARITY("EVEN"), .FIRST_BIT("LSB")) u_even (
        .clk(clk), .reset(reset), .rxd(rxd_even), .rx_data(data_even), .valid(valid_even),
        .parity_err(perr_even), .frame_err(ferr_even), .busy(busy_even));
    single_rx_uart #(.PARITY("ODD"), .FIRST_BIT("LSB")) u_odd (
        .clk(clk), .reset(reset), .rxd(rxd_odd), .rx_data(data_odd), .valid(valid_odd),
        .parity_err(perr_odd), .frame_err(ferr_odd), .busy(busy_odd));

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters; t_lsb holds the posedge index after which valid was seen.
    always @(negedge clk) begin
        if (valid_lsb) begin
            n_lsb <= n_lsb + 1;
            t_lsb <= cyc;
        end
        if (valid_msb)  n_msb  <= n_msb + 1;
        if (valid_even) n_even <= n_even + 1;
        if (valid_odd)  n_odd  <= n_odd + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the next posedge is E. pm: 0 none, 1 even, 2 odd.
    task automatic send_frame(input logic [7:0] b, input int pm, input bit msb,
                              input bit flip, input bit stopv);
        line  = 1'b0;
        e_cyc = cyc + 1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = msb ? b[7-i] : b[i];
            repeat (10) @(negedge clk);
        end
        if (pm != 0) begin
            line = (^b) ^ (pm == 2) ^ flip;
            repeat (10) @(negedge clk);
        end
        line = stopv;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_output("reset_lsb_outputs", {data_lsb, valid_lsb, perr_lsb, ferr_lsb, busy_lsb}, 32'h0);
        check_output("reset_other_outputs",
                     {data_msb, data_even, data_odd, valid_msb, valid_even, valid_odd,
                      perr_msb, perr_even, perr_odd, ferr_msb, ferr_even, ferr_odd,
                      busy_msb, busy_even, busy_odd}, 32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        sel  = 0;
        base = n_lsb;
        fork
            send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (2) @(negedge clk);
                check_output("a5_busy_e1", busy_lsb, 1'b0);
                @(negedge clk);
                check_output("a5_busy_e2", busy_lsb, 1'b1);
                repeat (94) @(negedge clk);
                check_output("a5_busy_e96", busy_lsb, 1'b1);
                check_output("a5_valid_e96", valid_lsb, 1'b0);
                @(negedge clk);
                check_output("a5_valid_e97", valid_lsb, 1'b1);
                check_output("a5_busy_e97", busy_lsb, 1'b0);
            end
        join
        check_output("a5_strobe_count", n_lsb - base, 1);
        check_output("a5_latency", t_lsb - e_cyc, 97);
        check_output("a5_data", data_lsb, 8'hA5);
        check_output("a5_errors", {perr_lsb, ferr_lsb}, 2'b00);

        sel  = 1;
        base = n_msb;
        send_frame(8'h3C, 0, 1'b1, 1'b0, 1'b1);
        check_output("msb_strobe_count", n_msb - base, 1);
        check_output("msb_data", data_msb, 8'h3C);
        check_output("msb_errors", {perr_msb, ferr_msb}, 2'b00);

        sel  = 2;
        base = n_even;
        send_frame(8'h07, 1, 1'b0, 1'b0, 1'b1);
        check_output("even_data", data_even, 8'h07);
        check_output("even_parity_ok", perr_even, 1'b0);
        send_frame(8'h07, 1, 1'b0, 1'b1, 1'b1);
        check_output("even_parity_bad", perr_even, 1'b1);
        check_output("even_strobe_count", n_even - base, 2);

        sel  = 3;
        base = n_odd;
        send_frame(8'h07, 2, 1'b0, 1'b0, 1'b1);
        check_output("odd_data", data_odd, 8'h07);
        check_output("odd_parity_ok", perr_odd, 1'b0);
        send_frame(8'h07, 2, 1'b0, 1'b1, 1'b1);
        check_output("odd_parity_bad", {perr_odd, ferr_odd}, 2'b10);
        check_output("odd_strobe_count", n_odd - base, 2);

        sel  = 0;
        repeat (5) @(negedge clk);
        base = n_lsb;
        line = 1'b0;
        repeat (2) @(negedge clk);
        line = 1'b1;
        @(negedge clk);
        check_output("glitch_busy_e2", busy_lsb, 1'b1);
        repeat (4) @(negedge clk);
        check_output("glitch_busy_e6", busy_lsb, 1'b1);
        @(negedge clk);
        check_output("glitch_busy_e7", busy_lsb, 1'b0);
        repeat (50) @(negedge clk);
        check_output("glitch_no_strobe", n_lsb - base, 0);
        check_output("glitch_held_outputs", {data_lsb, perr_lsb, ferr_lsb}, {8'hA5, 2'b00});

        base = n_lsb;
        send_frame(8'hC3, 0, 1'b0, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        check_output("break_single_strobe", n_lsb - base, 1);
        check_output("break_data", data_lsb, 8'hC3);
        check_output("break_frame_err", {perr_lsb, ferr_lsb}, 2'b01);
        check_output("break_busy_held", busy_lsb, 1'b1);
        line = 1'b1;
        repeat (5) @(negedge clk);
        check_output("break_released", busy_lsb, 1'b0);
        repeat (10) @(negedge clk);
        base = n_lsb;
        send_frame(8'h55, 0, 1'b0, 1'b0, 1'b1);
        check_output("after_break_count", n_lsb - base, 1);
        check_output("after_break_data", data_lsb, 8'h55);
        check_output("after_break_frame_err", ferr_lsb, 1'b0);

        base = n_lsb;
        send_frame(8'h00, 0, 1'b0, 1'b0, 1'b1);
        t1 = t_lsb;
        check_output("b2b_0_latency", t1 - e_cyc, 97);
        check_output("b2b_0_data", data_lsb, 8'h00);
        send_frame(8'hFF, 0, 1'b0, 1'b0, 1'b1);
        t2 = t_lsb;
        check_output("b2b_1_spacing", t2 - t1, 100);
        check_output("b2b_1_data", data_lsb, 8'hFF);
        send_frame(8'h81, 0, 1'b0, 1'b0, 1'b1);
        check_output("b2b_2_spacing", t_lsb - t2, 100);
        check_output("b2b_2_data", data_lsb, 8'h81);
        check_output("b2b_count", n_lsb - base, 3);
        check_output("b2b_errors", {perr_lsb, ferr_lsb}, 2'b00);

        base = n_lsb;
        fork
            send_frame(8'h12, 0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check_output("rst_mid_outputs",
                             {data_lsb, valid_lsb, perr_lsb, ferr_lsb, busy_lsb}, 32'h0);
                repeat (20) @(negedge clk);
                check_output("rst_mid_busy", busy_lsb, 1'b0);
            end
        join
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check_output("rst_no_strobe", n_lsb - base, 0);
        send_frame(8'h34, 0, 1'b0, 1'b0, 1'b1);
        check_output("rst_next_count", n_lsb - base, 1);
        check_output("rst_next_data", data_lsb, 8'h34);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/single_rx_uart.md
# single_rx_uart

Single-channel UART receiver; the companion stage to the single UART transmitter, consuming its `txd` line. It synchronises the asynchronous serial input, finds the start bit, samples each bit at mid-bit, optionally checks parity, checks the stop bit, and presents one received byte per frame with a single-cycle strobe. Frame format parameters match the transmitter exactly, so a transmitter and receiver with identical parameters form a loopback pair.

## Interface
- `CLOCK`, 10_000_000: clock frequency, Hz (int).
- `BAUD`, 1_000_000: baud rate (int). `CLOCK/BAUD >= 4` is required.
- `PARITY`, "NO": one of "ODD", "EVEN", "NO".
- `FIRST_BIT`, "LSB": "LSB" or "MSB"; the data bit order on the line.
- Derived (localparam): `factor_int = (CLOCK + BAUD/2) / BAUD` (bit length in clocks, rounded); `half_int = factor_int / 2`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `rxd` in 1: serial input, asynchronous to `clk`, idles high.
- `rx_data` out 8: last received byte, held until the next `valid`.
- `valid` out 1: one-cycle strobe; `rx_data`, `parity_err` and `frame_err` are updated in the same cycle.
- `parity_err` out 1: parity mismatch for the last frame; always 0 when PARITY="NO".
- `frame_err` out 1: stop bit was sampled low in the last frame.
- `busy` out 1: high while a frame is in progress.

## Operation
- Input synchroniser:
  - `rxd` passes through a 2-flop synchroniser that resets to 1.
  - All decisions use the synchronised signal `rxd_s`.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK. A bit counter (0..factor_int-1) and a data-bit index (0..7) run alongside.
- IDLE:
  - `rxd_s`=0 moves to START and clears the counter.
- START:
  - After `half_int` cycles, sample `rxd_s`.
  - If 0, go to DATA and reload the counter.
  - If 1, the start was a glitch: return to IDLE. No strobe, no flags.
- DATA:
  - Sample every `factor_int` cycles; 8 samples total.
  - LSB mode: shift right, new bit enters bit 7.
  - MSB mode: shift left, new bit enters bit 0.
  - After bit 8, go to PAR (if PARITY≠"NO") or STOP.
- PAR:
  - Sample one bit after `factor_int` cycles.
  - EVEN: error if XOR(data, parity bit) = 1.
  - ODD: error if XOR(data, parity bit) = 0.
- STOP:
  - Sample after `factor_int` cycles.
  - At that edge, register `rx_data`, `parity_err` and `frame_err`, and pulse `valid`.
  - If the stop bit is 1: go to IDLE immediately (mid-stop-bit). This lets a back-to-back frame be caught.
  - If the stop bit is 0: go to BREAK.
- BREAK:
  - Wait for `rxd_s`=1, then go to IDLE.
  - A line held low therefore produces exactly one `valid` with `frame_err`=1, never a stream of frames.
- `busy` = (state ≠ IDLE).
- Reset asserted at any time, including mid-frame:
  - state goes to IDLE and the counters clear;
  - `rx_data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0;
  - synchroniser flops go to 1.
- A partially received frame is discarded on reset; no strobe is issued.

## Timing
- Let E be the clk edge at which the raw `rxd` is first captured as 0 by synchroniser stage 1.
- `rxd_s` shows the falling edge at E+1. The FSM enters START at E+2.
- Sample points:
  - start-bit sample at E+2+half_int;
  - data bit k (k=0..7) at E+2+half_int+(k+1)·factor_int;
  - parity bit (if enabled) at E+2+half_int+9·factor_int;
  - stop bit at E+2+half_int+(9+p)·factor_int, where p=1 with parity and 0 without.
- `valid` is registered at the stop-sample edge: high for exactly the following cycle.
- `busy` falls on that same edge for a good stop bit.
- Back-to-back frames: a start edge arriving at any time after the stop-sample edge is detected. No idle time is required beyond the stop bit.
- Baud tolerance: cumulative mid-bit error must stay below ±half_int over 10–11 bits. This covers ±4 % skew at factor_int=10.

## Test plan
- Loopback with the transmitter, 10 MHz / 1 Mbaud, NO/LSB, send 0xA5:
  - `valid` pulses once, 97 cycles after E (2+5+9·10);
  - `rx_data`=0xA5, both errors 0;
  - `busy` high from E+2 to the stop sample.
- MSB mode, send 0x3C; EVEN parity, send 0x07; ODD parity, send 0x07:
  - `rx_data` is correct in each case and `parity_err`=0;
  - forcing the parity bit inverted gives `parity_err`=1.
- 2-cycle low glitch on `rxd`:
  - `busy` rises, then falls after the start sample;
  - no `valid`, no flag changes.
- Stop bit driven 0, then line held low for 30 bit times:
  - exactly one `valid`, with `frame_err`=1;
  - FSM stays in BREAK until `rxd` returns high;
  - a following good frame 0x55 is received with `frame_err`=0.
- Three back-to-back transmitter frames (0x00, 0xFF, 0x81), no idle gap:
  - three `valid` pulses spaced 100 cycles apart;
  - data correct, no errors.
- Reset asserted mid-DATA of frame 0x12, released, then frame 0x34 sent:
  - all outputs 0 during reset;
  - no strobe for 0x12;
  - `rx_data`=0x34 on the next `valid`.
